mem_access_controller: RTL and testbench

- Sequences multi-cycle accesses to an external 16-bit asynchronous SRAM on behalf of the MEM stage.
- Each 32-bit word is moved as two half-word phases, low half first.
- While an access is in flight the block asserts freeze. Upstream pipeline registers use freeze to drop their enable, and the MEM/WB register loads only on the ready cycle.

---
 rtl/mem_access_controller.sv | 163 ++++++++++++++++
 tb/tb_mem_access_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// Sequences 32-bit CPU loads/stores as two 16-bit SRAM phases (low half first).
// Optional macro MEM_CTRL_STALL_CNT_EN adds a saturating stall_count output.
module mem_access_controller #(
  parameter int N           = 32,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [N-1:0]       ALU_Res,
  input  logic [N-1:0]       Val_Rm,
  output logic [N-1:0]       ReadData,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_WDATA,
  input  logic [15:0]        SRAM_RDATA,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
`ifdef MEM_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]        stall_count
`endif
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic       WE_GAP   = (WAIT_CYCLES > 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [SRAM_AW-2:0]   addr_q, addr_d;
  logic [N-1:0]         data_q, data_d;
  logic                 wr_q, wr_d;
  logic [N-1:0]         rdata_q, rdata_d;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic [15:0]          sram_wdata_q, sram_wdata_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;

  logic [N-1:0]         offset;
  logic [SRAM_AW-2:0]   word;
  logic                 req;
  logic                 unused_addr_bits;

  assign offset = ALU_Res - N'(BASE_ADDR);
  assign word   = offset[SRAM_AW:2];
  assign req    = MEM_R_EN | MEM_W_EN;
  assign unused_addr_bits = ^{offset[N-1:SRAM_AW+1], offset[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wr_d         = wr_q;
    rdata_d      = rdata_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d      = word;
          data_d      = Val_Rm;
          wr_d        = MEM_W_EN;
          cnt_d       = CNT_LOAD;
          sram_addr_d = {word, 1'b0};
          if (MEM_W_EN) sram_wdata_d = Val_Rm[15:0];
          we_n_d      = ~MEM_W_EN;
          oe_n_d      = MEM_W_EN;
          state_d     = LO;
        end
      end
      LO: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) rdata_d[15:0] = SRAM_RDATA;
          cnt_d       = CNT_LOAD;
          sram_addr_d = {addr_q, 1'b1};
          if (wr_q) sram_wdata_d = data_q[31:16];
          // WE_N pulses high across the address change so the low half commits first
          we_n_d      = wr_q ? WE_GAP : 1'b1;
          state_d     = HI;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HI: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) rdata_d[31:16] = SRAM_RDATA;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          we_n_d = ~wr_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 16'd0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      rdata_q      <= rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
    end
  end

  assign freeze     = req & (state_q != DONE);
  assign ready      = (state_q == DONE);
  assign ReadData   = rdata_q;
  assign SRAM_ADDR  = sram_addr_q;
  assign SRAM_WDATA = sram_wdata_q;
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_OE_N  = oe_n_q;

`ifdef MEM_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_cnt_q <= 32'd0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: one instance with WAIT_CYCLES=5 and one with 1,
// each backed by a simple SRAM array; expectations derived per cycle from access timing rules.
module tb_mem_access_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr;
  logic [31:0] alu_res, val_rm;
  logic        sel;

  logic [31:0] rd5, rd1;
  logic        rdy5, rdy1, frz5, frz1, we5, we1, oe5, oe1;
  logic [17:0] addr5, addr1;
  logic [15:0] wd5, wd1, rdat5, rdat1;
`ifdef MEM_CTRL_STALL_CNT_EN
  logic [31:0] stall5, stall1;
`endif

  logic [15:0] mem5 [0:1023];
  logic [15:0] mem1 [0:1023];

  logic [31:0] o_rd;
  logic        o_rdy, o_frz, o_we, o_oe;
  logic [17:0] o_addr;
  logic [15:0] o_wd;

  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_access_controller #(.N(32), .SRAM_AW(18), .WAIT_CYCLES(5), .BASE_ADDR(1024)) u_dut5 (
    .clk(clk), .rst(rst), .MEM_R_EN(req_rd & ~sel), .MEM_W_EN(req_wr & ~sel),
    .ALU_Res(alu_res), .Val_Rm(val_rm), .ReadData(rd5), .ready(rdy5), .freeze(frz5),
    .SRAM_ADDR(addr5), .SRAM_WDATA(wd5), .SRAM_RDATA(rdat5), .SRAM_WE_N(we5), .SRAM_OE_N(oe5)
`ifdef MEM_CTRL_STALL_CNT_EN
    , .stall_count(stall5)
`endif
  );

  mem_access_controller #(.N(32), .SRAM_AW(18), .WAIT_CYCLES(1), .BASE_ADDR(1024)) u_dut1 (
    .clk(clk), .rst(rst), .MEM_R_EN(req_rd & sel), .MEM_W_EN(req_wr & sel),
    .ALU_Res(alu_res), .Val_Rm(val_rm), .ReadData(rd1), .ready(rdy1), .freeze(frz1),
    .SRAM_ADDR(addr1), .SRAM_WDATA(wd1), .SRAM_RDATA(rdat1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1)
`ifdef MEM_CTRL_STALL_CNT_EN
    , .stall_count(stall1)
`endif
  );

  // Asynchronous SRAM approximated as combinational read, write while WE_N is low
  assign rdat5 = mem5[addr5[9:0]];
  assign rdat1 = mem1[addr1[9:0]];
  always @(posedge clk) if (!we5) mem5[addr5[9:0]] <= wd5;
  always @(posedge clk) if (!we1) mem1[addr1[9:0]] <= wd1;

  assign o_rd   = sel ? rd1   : rd5;
  assign o_rdy  = sel ? rdy1  : rdy5;
  assign o_frz  = sel ? frz1  : frz5;
  assign o_we   = sel ? we1   : we5;
  assign o_oe   = sel ? oe1   : oe5;
  assign o_addr = sel ? addr1 : addr5;
  assign o_wd   = sel ? wd1   : wd5;

  // Runs one access on the selected instance, checking every cycle from acceptance to ready
  task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] data, input bit hold, input bit drop_end);
    int          w;
    int          key;
    logic [16:0] word;
    logic [31:0] exp_word;
    logic        lo, hi, exp_frz, exp_rdy, exp_we, exp_oe;
    w        = sel ? 1 : 5;
    word     = 17'((addr - 32'd1024) >> 2);
    key      = int'(sel) * 65536 + int'(word);
    exp_word = wr ? data : ref_mem[key];
    alu_res  = addr;
    val_rm   = data;
    req_wr   = wr;
    req_rd   = rd;
    for (int k = 0; k <= 2 * w + 1; k++) begin
      @(negedge clk);
      lo      = (k >= 1) && (k <= w);
      hi      = (k > w) && (k <= 2 * w);
      exp_frz = (k == 0) || (hold && (k != 2 * w + 1));
      exp_rdy = (k == 2 * w + 1);
      exp_we  = (wr && (lo || (hi && !(k == w + 1 && w > 1)))) ? 1'b0 : 1'b1;
      exp_oe  = (!wr && (lo || hi)) ? 1'b0 : 1'b1;
      total++;
      if (o_frz !== exp_frz) begin bad++; $display("[TB] FAIL freeze w=%0d k=%0d got=%b exp=%b", w, k, o_frz, exp_frz); end
      total++;
      if (o_rdy !== exp_rdy) begin bad++; $display("[TB] FAIL ready w=%0d k=%0d got=%b exp=%b", w, k, o_rdy, exp_rdy); end
      total++;
      if (o_we !== exp_we) begin bad++; $display("[TB] FAIL we_n w=%0d k=%0d got=%b exp=%b", w, k, o_we, exp_we); end
      total++;
      if (o_oe !== exp_oe) begin bad++; $display("[TB] FAIL oe_n w=%0d k=%0d got=%b exp=%b", w, k, o_oe, exp_oe); end
      if (lo || hi) begin
        total++;
        if (o_addr !== {word, hi}) begin bad++; $display("[TB] FAIL sram_addr w=%0d k=%0d got=%0h exp=%0h", w, k, o_addr, {word, hi}); end
      end
      if (wr && (lo || hi)) begin
        total++;
        if (o_wd !== (lo ? data[15:0] : data[31:16])) begin
          bad++; $display("[TB] FAIL wdata w=%0d k=%0d got=%h exp=%h", w, k, o_wd, lo ? data[15:0] : data[31:16]);
        end
      end
      if (k == 2 * w + 1) begin
        total++;
        if (o_rd !== (wr ? exp_rd[sel] : exp_word)) begin
          bad++; $display("[TB] FAIL read_data w=%0d got=%h exp=%h", w, o_rd, wr ? exp_rd[sel] : exp_word);
        end
      end
      @(posedge clk);
      #1;
      if (k == 0 && !hold) begin req_wr = 1'b0; req_rd = 1'b0; end
    end
    if (drop_end) begin req_wr = 1'b0; req_rd = 1'b0; end
    if (wr) ref_mem[key] = data;
    else    exp_rd[sel] = exp_word;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      @(negedge clk);
      total++;
      if (o_rd !== 32'd0) begin bad++; $display("[TB] FAIL reset_read_data got=%h exp=0", o_rd); end
      total++;
      if (o_rdy !== 1'b0 || o_frz !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready_freeze got=%b%b exp=00", o_rdy, o_frz); end
      total++;
      if (o_addr !== 18'd0 || o_wd !== 16'd0) begin bad++; $display("[TB] FAIL reset_addr_wdata got=%h/%h exp=0/0", o_addr, o_wd); end
      total++;
      if (o_we !== 1'b1 || o_oe !== 1'b1) begin bad++; $display("[TB] FAIL reset_strobes got=%b%b exp=11", o_we, o_oe); end
    end
    sel = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
  endtask

  task automatic test_store_load();
    sel = 1'b0;
    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b1, 1'b1);
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, 1'b1);
`ifdef MEM_CTRL_STALL_CNT_EN
    total++;
    if (stall5 !== 32'd22) begin bad++; $display("[TB] FAIL stall_count got=%0d exp=22", stall5); end
`endif
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_access(1'b1, 1'b0, 32'd1028, 32'h1111_2222, 1'b1, 1'b0);
    run_access(1'b1, 1'b0, 32'd1032, 32'h3333_4444, 1'b1, 1'b1);
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1, 1'b1);
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_req_drop();
    sel = 1'b0;
    run_access(1'b1, 1'b0, 32'd1040, 32'hA5A5_5A5A, 1'b0, 1'b1);
    run_access(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    sel     = 1'b0;
    alu_res = 32'd1024;
    val_rm  = 32'h1234_5678;
    req_wr  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (o_we !== 1'b0) begin bad++; $display("[TB] FAIL abort_pre_we_n got=%b exp=0", o_we); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (o_we !== 1'b1 || o_oe !== 1'b1) begin bad++; $display("[TB] FAIL abort_strobes got=%b%b exp=11", o_we, o_oe); end
    total++;
    if (o_rdy !== 1'b0) begin bad++; $display("[TB] FAIL abort_ready got=%b exp=0", o_rdy); end
    total++;
    if (o_frz !== 1'b1) begin bad++; $display("[TB] FAIL abort_freeze got=%b exp=1", o_frz); end
    @(posedge clk);
    #1;
    rst    = 1'b1;
    req_wr = 1'b0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    run_access(1'b1, 1'b0, 32'd1024, 32'hCAFE_F00D, 1'b1, 1'b1);
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_wait1();
    sel = 1'b1;
    run_access(1'b1, 1'b1, 32'd1024, 32'h0BAD_F00D, 1'b1, 1'b1);
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, 1'b1);
    run_access(1'b1, 1'b0, 32'd1100, 32'h7654_3210, 1'b1, 1'b0);
    run_access(1'b0, 1'b1, 32'd1101, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int          op;
    int          key;
    logic [31:0] addr;
    for (int i = 0; i < 24; i++) begin
      sel  = 1'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 2));
      addr = 32'd1024 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
      key  = int'(sel) * 65536 + int'((addr - 32'd1024) >> 2);
      if (op == 1 && !ref_mem.exists(key)) op = 0;
      run_access(op != 1, op != 0, addr, $urandom, 1'($urandom_range(0, 1)),
                 (i == 23) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    req_wr = 1'b0;
    req_rd = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    req_rd  = 1'b0;
    req_wr  = 1'b0;
    alu_res = 32'd0;
    val_rm  = 32'd0;
    sel     = 1'b0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_req_drop();
    test_reset_mid();
    test_wait1();
    test_random();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
